// File: rtl/fetch_mem_unit.sv
// Owns PC, IR and MDR, and runs the request/ready handshake to the unified memory for the multicycle core.
// Latency: a zero-wait access updates IR/MDR/PC at the request edge; an N-wait access updates them N cycles later.
// Backpressure: while MemReady is low the request stays asserted with latched address/data and Stall holds the control unit.
module fetch_mem_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             PcWrite,
    input  logic             Branch,
    input  logic             Zero,
    input  logic             PcSrc,
    input  logic             IorD,
    input  logic             IRWrite,
    input  logic             MemWrite,
    input  logic [WIDTH-1:0] ALUResult,
    input  logic [WIDTH-1:0] ALUOut,
    input  logic [WIDTH-1:0] WriteData,
    output logic [WIDTH-1:0] MemAddr,
    output logic [WIDTH-1:0] MemWData,
    output logic             MemReq,
    output logic             MemWE,
    input  logic [WIDTH-1:0] MemRData,
    input  logic             MemReady,
    output logic             Stall,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] Instr,
    output logic [5:0]       OpCode,
    output logic [5:0]       Function,
    output logic [WIDTH-1:0] MemData
);

    // Clears the two byte-offset bits so every address and PC value is word aligned.
    localparam logic [WIDTH-1:0] WORD_MASK = ~(WIDTH'(3));

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] addrQ;
    logic [WIDTH-1:0] wdataQ;
    logic             weQ;
    logic             fetchQ;
    logic [WIDTH-1:0] irQ;
    logic [WIDTH-1:0] mdrQ;

    logic             access;
    logic             dataSel;
    logic [WIDTH-1:0] selAddr;
    logic [WIDTH-1:0] nextPc;
    logic             reqInt;
    logic [WIDTH-1:0] addrInt;
    logic [WIDTH-1:0] wdataInt;
    logic             weInt;
    logic             fetchInt;
    logic             complete;
    logic             pcEn;

    // Any memory command opens an access; stores and IorD loads go to ALUOut, plain fetches go to PC.
    assign access  = IRWrite | MemWrite | IorD;
    assign dataSel = MemWrite | IorD;
    assign selAddr = dataSel ? ALUOut : PC;
    assign nextPc  = PcSrc ? ALUOut : ALUResult;

    // Request attributes: live from the control unit in IDLE, frozen copies while waiting.
    always_comb begin
        reqInt   = 1'b0;
        addrInt  = '0;
        wdataInt = '0;
        weInt    = 1'b0;
        fetchInt = 1'b0;
        if (state == WAIT) begin
            reqInt   = 1'b1;
            addrInt  = addrQ;
            wdataInt = wdataQ;
            weInt    = weQ;
            fetchInt = fetchQ;
        end else if (access) begin
            reqInt   = 1'b1;
            addrInt  = selAddr & WORD_MASK;
            wdataInt = WriteData;
            weInt    = MemWrite;
            fetchInt = IRWrite & ~dataSel;
        end
    end

    // Reset masks the handshake immediately so an abandoned access never reaches memory.
    assign MemReq   = RST_N & reqInt;
    assign MemWE    = RST_N & reqInt & weInt;
    assign MemAddr  = addrInt;
    assign MemWData = wdataInt;
    assign Stall    = MemReq & ~MemReady;
    assign complete = MemReq & MemReady;

    // PC only moves on a non-stalled cycle, so a fetch never lets PC run ahead of IR.
    assign pcEn = (PcWrite | (Branch & Zero)) & ~Stall;

    // Handshake FSM plus the PC/IR/MDR architectural registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state  <= IDLE;
            addrQ  <= '0;
            wdataQ <= '0;
            weQ    <= 1'b0;
            fetchQ <= 1'b0;
            PC     <= RESET_PC;
            irQ    <= '0;
            mdrQ   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access && !MemReady) begin
                        state  <= WAIT;
                        addrQ  <= addrInt;
                        wdataQ <= wdataInt;
                        weQ    <= weInt;
                        fetchQ <= fetchInt;
                    end
                end
                WAIT: begin
                    if (MemReady) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (complete && !weInt) begin
                mdrQ <= MemRData;
                if (fetchInt) begin
                    irQ <= MemRData;
                end
            end

            if (pcEn) begin
                PC <= nextPc & WORD_MASK;
            end
        end
    end

    assign Instr    = irQ;
    assign MemData  = mdrQ;
    assign OpCode   = irQ[31:26];
    assign Function = irQ[5:0];

endmodule
